rvfi_retire_fifo: RTL and testbench

- Sits directly downstream of the 2-stage RVFI tracer and consumes its registered rvfi_* beat stream.
- Captures a fixed subset of every retired-instruction record (rvfi_valid=1) into a DEPTH-entry FIFO.
- Presents records to the contract-observation logic over a valid/ready drain port.
- Checks rvfi_order continuity and flags dropped records; sticky error flags let the harness reject a corrupted trace.

---
 rtl/rvfi_retire_fifo.sv | 195 +++++++++++++++++++
 tb/tb_rvfi_retire_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_fifo.sv
// rvfi_retire_fifo
//   Captures every retired-instruction beat from the registered RVFI tracer
//   stream into a DEPTH-entry show-ahead FIFO. Records drain to the
//   contract-observation logic over a valid/ready port. The block also checks
//   that rvfi_order is continuous and flags any beat it had to drop.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   clear               synchronous flush of FIFO, flags and order tracking
//   rvfi_*              retire beat from the tracer (rvfi_valid qualifies it)
//   out_valid/out_ready drain handshake; out_* carry the head record
//   count               occupancy, 0..DEPTH
//   overflow            sticky, set when at least one beat was dropped
//   drop_count          dropped beats, saturates at 16'hFFFF
//   order_error         sticky, set on any rvfi_order discontinuity
module rvfi_retire_fifo #(
    parameter int          DEPTH       = 8,
    parameter int          CNT_W       = 4,
    parameter logic [63:0] FIRST_ORDER = 64'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             rvfi_valid,
    input  logic [63:0]      rvfi_order,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic [31:0]      rvfi_pc_rdata,
    input  logic [31:0]      rvfi_pc_wdata,
    input  logic [4:0]       rvfi_rd_addr,
    input  logic [31:0]      rvfi_rd_wdata,
    input  logic [31:0]      rvfi_mem_addr,
    input  logic [3:0]       rvfi_mem_rmask,
    input  logic [3:0]       rvfi_mem_wmask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_order,
    output logic [31:0]      out_insn,
    output logic             out_trap,
    output logic [31:0]      out_pc_rdata,
    output logic [31:0]      out_pc_wdata,
    output logic [4:0]       out_rd_addr,
    output logic [31:0]      out_rd_wdata,
    output logic [31:0]      out_mem_addr,
    output logic [3:0]       out_mem_rmask,
    output logic [3:0]       out_mem_wmask,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [15:0]      drop_count,
    output logic             order_error
);

    localparam int               AW   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             wr_rec;
    rec_t             head;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_q, drop_d;
    logic             order_err_q, order_err_d;
    logic             expect_first_q, expect_first_d;
    logic [63:0]      last_order_q, last_order_d;

    logic             pop, push, drop;
    logic [63:0]      exp_order;

    assign out_valid = (count_q != '0);

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = rvfi_valid & ((count_q != FULL) | pop) & ~clear;
    assign drop = rvfi_valid & (count_q == FULL) & ~pop;

    assign exp_order = expect_first_q ? FIRST_ORDER : (last_order_q + 64'd1);

    assign wr_rec = '{
        order:     rvfi_order,
        insn:      rvfi_insn,
        trap:      rvfi_trap,
        pc_rdata:  rvfi_pc_rdata,
        pc_wdata:  rvfi_pc_wdata,
        rd_addr:   rvfi_rd_addr,
        rd_wdata:  rvfi_rd_wdata,
        mem_addr:  rvfi_mem_addr,
        mem_rmask: rvfi_mem_rmask,
        mem_wmask: rvfi_mem_wmask
    };

    // Storage has no reset; gating the head on out_valid keeps out_* at zero
    // whenever the FIFO is empty, including straight after reset or clear.
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_order     = head.order;
    assign out_insn      = head.insn;
    assign out_trap      = head.trap;
    assign out_pc_rdata  = head.pc_rdata;
    assign out_pc_wdata  = head.pc_wdata;
    assign out_rd_addr   = head.rd_addr;
    assign out_rd_wdata  = head.rd_wdata;
    assign out_mem_addr  = head.mem_addr;
    assign out_mem_rmask = head.mem_rmask;
    assign out_mem_wmask = head.mem_wmask;

    assign count       = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign order_error = order_err_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        drop_d         = drop_q;
        order_err_d    = order_err_q;
        expect_first_d = expect_first_q;
        last_order_d   = last_order_q;

        if (clear) begin
            // Flush wins over everything; the beat in this cycle is discarded.
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            overflow_d     = 1'b0;
            drop_d         = '0;
            order_err_d    = 1'b0;
            expect_first_d = 1'b1;
            last_order_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end

            // Dropped beats are order-checked too. last_order follows the
            // received value so a single gap flags once, not on every beat.
            if (rvfi_valid) begin
                if (rvfi_order != exp_order) order_err_d = 1'b1;
                expect_first_d = 1'b0;
                last_order_d   = rvfi_order;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            drop_q         <= '0;
            order_err_q    <= 1'b0;
            expect_first_q <= 1'b1;
            last_order_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            drop_q         <= drop_d;
            order_err_q    <= order_err_d;
            expect_first_q <= expect_first_d;
            last_order_q   <= last_order_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
module tb_rvfi_retire_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_pc_wdata = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_mem_addr = '0;
    logic [3:0]  rvfi_mem_rmask = '0;
    logic [3:0]  rvfi_mem_wmask = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_order;
    logic [31:0] out_insn;
    logic        out_trap;
    logic [31:0] out_pc_rdata;
    logic [31:0] out_pc_wdata;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_wdata;
    logic [31:0] out_mem_addr;
    logic [3:0]  out_mem_rmask;
    logic [3:0]  out_mem_wmask;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        order_error;

    int n_checks = 0;
    int n_err    = 0;

    rvfi_retire_fifo #(.DEPTH(8), .CNT_W(4), .FIRST_ORDER(64'd1)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_insn(out_insn), .out_trap(out_trap), .out_pc_rdata(out_pc_rdata),
        .out_pc_wdata(out_pc_wdata), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .order_error(order_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one retire beat; pc_rdata follows 0x100 + 4*(order-1).
    task automatic beat(input logic [63:0] ord);
        rvfi_valid     = 1'b1;
        rvfi_order     = ord;
        rvfi_insn      = 32'h0000_0013;
        rvfi_trap      = 1'b0;
        rvfi_pc_rdata  = 32'h100 + 32'(ord - 64'd1) * 32'd4;
        rvfi_pc_wdata  = 32'h104 + 32'(ord - 64'd1) * 32'd4;
        rvfi_rd_addr   = 5'd0;
        rvfi_rd_wdata  = 32'd0;
        rvfi_mem_addr  = 32'd0;
        rvfi_mem_rmask = 4'd0;
        rvfi_mem_wmask = 4'd0;
    endtask

    task automatic idle();
        rvfi_valid = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_order", out_order, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_oerr", order_error, 0);
        reset = 1'b1;
        tick();

        // Basic streaming with out_ready=1
        out_ready = 1'b1;
        beat(1); tick();
        check("basic_v1", out_valid, 1);
        check("basic_o1", out_order, 1);
        check("basic_pc1", out_pc_rdata, 32'h100);
        check("basic_c1", count, 1);
        beat(2); tick();
        check("basic_o2", out_order, 2);
        check("basic_pc2", out_pc_rdata, 32'h104);
        check("basic_c2", count, 1);
        beat(3); tick();
        check("basic_o3", out_order, 3);
        check("basic_pc3", out_pc_rdata, 32'h108);
        check("basic_c3", count, 1);
        idle(); tick();
        check("basic_empty", count, 0);
        check("basic_v0", out_valid, 0);
        check("basic_oerr", order_error, 0);
        check("basic_ovf", overflow, 0);

        // Fill and overflow
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            beat(64'(i)); tick();
        end
        idle();
        check("fill_count", count, 8);
        check("fill_ovf", overflow, 1);
        check("fill_drop", drop_count, 2);
        check("fill_oerr", order_error, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("fill_drain_order", out_order, 64'(i));
            tick();
        end
        check("fill_drained", count, 0);

        // Full with simultaneous push and pop
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            beat(64'(i)); tick();
        end
        check("fp_full", count, 8);
        out_ready = 1'b1;
        beat(9); tick();
        idle();
        check("fp_count", count, 8);
        check("fp_head", out_order, 2);
        check("fp_ovf", overflow, 0);
        check("fp_drop", drop_count, 0);
        for (int i = 2; i <= 9; i++) begin
            check("fp_drain_order", out_order, 64'(i));
            tick();
        end
        check("fp_empty", count, 0);

        // Order gap 1,2,4,5
        do_clear();
        out_ready = 1'b0;
        beat(1); tick();
        beat(2); tick();
        check("gap_pre", order_error, 0);
        beat(4); tick();
        check("gap_rise", order_error, 1);
        beat(5); tick();
        idle();
        check("gap_hold", order_error, 1);
        check("gap_count", count, 4);
        out_ready = 1'b1;
        check("gap_d1", out_order, 1); tick();
        check("gap_d2", out_order, 2); tick();
        check("gap_d4", out_order, 4); tick();
        check("gap_d5", out_order, 5); tick();

        // Wrong first order
        do_clear();
        check("first_clean", order_error, 0);
        out_ready = 1'b0;
        beat(0); tick();
        idle();
        check("first_wrong", order_error, 1);
        check("first_stored", count, 1);

        // Backpressure hold with every field exercised
        do_clear();
        out_ready = 1'b0;
        beat(1);
        rvfi_insn      = 32'h0050_0093;
        rvfi_trap      = 1'b1;
        rvfi_pc_rdata  = 32'h0000_0200;
        rvfi_pc_wdata  = 32'h0000_0204;
        rvfi_rd_addr   = 5'd1;
        rvfi_rd_wdata  = 32'd5;
        rvfi_mem_addr  = 32'hDEAD_BEE0;
        rvfi_mem_rmask = 4'hF;
        rvfi_mem_wmask = 4'h3;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_insn", out_insn, 32'h0050_0093);
            check("bp_order", out_order, 1);
            check("bp_rdw", out_rd_wdata, 5);
            tick();
        end
        check("bp_trap", out_trap, 1);
        check("bp_pcr", out_pc_rdata, 32'h200);
        check("bp_pcw", out_pc_wdata, 32'h204);
        check("bp_rda", out_rd_addr, 1);
        check("bp_maddr", out_mem_addr, 32'hDEAD_BEE0);
        check("bp_rmask", out_mem_rmask, 4'hF);
        check("bp_wmask", out_mem_wmask, 4'h3);

        // Clear and reset mid-operation
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            beat(64'(i)); tick();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        beat(12); tick();
        check("mid_count", count, 5);
        check("mid_oerr", order_error, 1);
        check("mid_ovf", overflow, 1);
        check("mid_drop", drop_count, 2);
        beat(13);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        check("clr_count", count, 0);
        check("clr_valid", out_valid, 0);
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_count, 0);
        check("clr_oerr", order_error, 0);
        beat(1); tick();
        idle();
        check("clr_rearm_oerr", order_error, 0);
        check("clr_rearm_order", out_order, 1);
        check("clr_rearm_count", count, 1);
        #3 reset = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", out_valid, 0);
        check("arst_order", out_order, 0);
        check("arst_insn", out_insn, 0);
        reset = 1'b1;
        tick();
        check("arst_after", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
